// File: rtl/mem_responder_if.sv
// Request/response bundle between the memory buffer (master) and mem_responder (slave).
// A transfer happens on an edge where valid & ready are both high; a producer holds its
// payload stable while valid is high and ready is low, and ready never depends on valid.
interface mem_responder_if #(
  parameter int ROB_AW = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [15:0]       req_addr;
  logic [15:0]       req_wdata;
  logic [ROB_AW-1:0] req_rob;

  logic              resp_valid;
  logic              resp_ready;
  logic              resp_store;
  logic [ROB_AW-1:0] resp_rob;
  logic [15:0]       resp_rdata;
  logic              resp_fault;

  modport master (
    output req_valid, req_store, req_addr, req_wdata, req_rob, resp_ready,
    input  req_ready, resp_valid, resp_store, resp_rob, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_store, req_addr, req_wdata, req_rob, resp_ready,
    output req_ready, resp_valid, resp_store, resp_rob, resp_rdata, resp_fault
  );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder: fixed-latency word RAM access, completions in a FIFO.
// Optional address fault detection is enabled with `define MEM_RESPONDER_FAULT_EN.
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int ROB_AW  = 5,
  parameter int RESPQ   = 4
) (
  input  logic             clk,
  input  logic             rst,
  mem_responder_if.slave   bus,
  output logic [1:0]       dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(RESPQ);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [PW:0] QCAP = (PW+1)'(RESPQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CW-1:0]     lat_cnt;
  logic              st_q;
  logic [15:0]       addr_q;
  logic [15:0]       wdata_q;
  logic [ROB_AW-1:0] rob_q;

  logic [15:0]       ram [DEPTH];

  logic              q_store [RESPQ];
  logic [ROB_AW-1:0] q_rob   [RESPQ];
  logic [15:0]       q_rdata [RESPQ];
  logic              q_fault [RESPQ];
  logic [PW:0]       wr_ptr;
  logic [PW:0]       rd_ptr;
  logic [PW:0]       count;

  logic [AW-1:0]     idx;
  logic              fault;
  logic              accept;
  logic              pop;
  logic [15:0]       rd_word;

  assign idx = addr_q[AW-1:0];

`ifdef MEM_RESPONDER_FAULT_EN
  assign fault = |(addr_q >> AW);
`else
  // High address bits alias onto the RAM; they are deliberately dropped.
  logic unused_hi;
  assign unused_hi = |(addr_q >> AW);
  assign fault     = 1'b0;
`endif

  assign count   = wr_ptr - rd_ptr;
  assign rd_word = fault ? 16'h0000 : ram[idx];

  // rst gates ready so nothing is accepted while reset is held.
  assign bus.req_ready  = ~rst & (state == S_IDLE) & (count < QCAP);
  assign accept         = bus.req_valid & bus.req_ready;
  assign bus.resp_valid = (wr_ptr != rd_ptr);
  assign pop            = bus.resp_valid & bus.resp_ready;

  assign bus.resp_store = q_store[rd_ptr[PW-1:0]];
  assign bus.resp_rob   = q_rob[rd_ptr[PW-1:0]];
  assign bus.resp_rdata = q_rdata[rd_ptr[PW-1:0]];
  assign bus.resp_fault = q_fault[rd_ptr[PW-1:0]];
  assign dbg_state      = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
      st_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rob_q   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      for (int i = 0; i < RESPQ; i++) begin
        q_store[i] <= 1'b0;
        q_rob[i]   <= '0;
        q_rdata[i] <= '0;
        q_fault[i] <= 1'b0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            st_q    <= bus.req_store;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            rob_q   <= bus.req_rob;
            if (LATENCY == 1) begin
              state <= S_DONE;
            end else begin
              state   <= S_WAIT;
              lat_cnt <= CW'(LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == CW'(1)) state <= S_DONE;
        end
        S_DONE: begin
          // Space was reserved at acceptance, so this push never overflows.
          q_store[wr_ptr[PW-1:0]] <= st_q;
          q_rob[wr_ptr[PW-1:0]]   <= rob_q;
          q_rdata[wr_ptr[PW-1:0]] <= st_q ? 16'h0000 : rd_word;
          q_fault[wr_ptr[PW-1:0]] <= fault;
          wr_ptr                  <= wr_ptr + 1'b1;
          state                   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // RAM is not reset; a store only commits in DONE, so reset discards an in-flight store.
  always_ff @(posedge clk) begin
    if (state == S_DONE && st_q && !fault) ram[idx] <= wdata_q;
  end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: table vectors, directed corner sequences and randomized traffic
// against an accept-order reference model. Honours `define MEM_RESPONDER_FAULT_EN.
module tb_mem_responder;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;
  localparam int ROB_AW  = 5;
  localparam int RESPQ   = 4;
  localparam int W       = 1 + ROB_AW + 16 + 1;
`ifdef MEM_RESPONDER_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  mem_responder_if #(.ROB_AW(ROB_AW)) bus ();

  mem_responder #(
    .DEPTH(DEPTH), .LATENCY(LATENCY), .ROB_AW(ROB_AW), .RESPQ(RESPQ)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0]  model_mem [DEPTH];
  logic [W-1:0] mon_got;
  logic [W-1:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a request's completion is fully determined at acceptance, since requests
  // are served one at a time in acceptance order.
  task automatic model_accept(input logic st, input logic [15:0] addr, input logic [15:0] wd,
                              input logic [ROB_AW-1:0] rob);
    int  i;
    logic flt;
    i   = addr % DEPTH;
    flt = FAULT_EN && (addr >= DEPTH);
    if (st) begin
      if (!flt) model_mem[i] = wd;
      exp_q.push_back({1'b1, rob, 16'h0000, flt});
    end else begin
      exp_q.push_back({1'b0, rob, flt ? 16'h0000 : model_mem[i], flt});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic st, input logic [15:0] addr, input logic [15:0] wd,
                      input logic [ROB_AW-1:0] rob);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_store = st;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_rob   = rob;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("send_ready", bus.req_ready, 1);
    if (bus.req_ready) begin
      @(posedge clk); #1;
      model_accept(st, addr, wd, rob);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic st, input logic [ROB_AW-1:0] rob,
                           input logic [15:0] rd, input logic flt);
    int n;
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_valid"}, bus.resp_valid, 1);
    check({name, "_store"}, bus.resp_store, st);
    check({name, "_rob"},   bus.resp_rob, rob);
    check({name, "_rdata"}, bus.resp_rdata, rd);
    check({name, "_fault"}, bus.resp_fault, flt);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.resp_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.resp_valid) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("drain_empty", exp_q.size(), 0);
    check("drain_valid", bus.resp_valid, 0);
    bus.resp_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && bus.resp_valid && bus.resp_ready) begin
      mon_got = {bus.resp_store, bus.resp_rob, bus.resp_rdata, bus.resp_fault};
      if (exp_q.size() == 0) begin
        check("sb_unexpected", mon_got, '1);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sb_completion", mon_got, mon_exp);
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic              st;
    logic [15:0]       addr;
    logic [15:0]       wd;
    logic [ROB_AW-1:0] rob;
    logic [15:0]       exp_rdata;
  } vec_t;
  vec_t vecs[8];

  logic        rand_done;
  logic [15:0] ra;
  logic [15:0] saved;

  initial begin
    vecs[0] = '{1'b1, 16'h0021, 16'hBEEF, 5'd4,  16'h0000};
    vecs[1] = '{1'b0, 16'h0021, 16'h0000, 5'd5,  16'hBEEF};
    vecs[2] = '{1'b1, 16'h00FF, 16'h1111, 5'd6,  16'h0000};
    vecs[3] = '{1'b0, 16'h00FF, 16'h0000, 5'd7,  16'h1111};
    vecs[4] = '{1'b1, 16'h0000, 16'hA5A5, 5'd8,  16'h0000};
    vecs[5] = '{1'b0, 16'h0000, 16'h0000, 5'd9,  16'hA5A5};
    vecs[6] = '{1'b1, 16'h0021, 16'h7777, 5'd10, 16'h0000};
    vecs[7] = '{1'b0, 16'h0021, 16'h0000, 5'd11, 16'h7777};

    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_rob    = '0;
    bus.resp_ready = 1'b0;

    // Reset values while rst is held.
    #2;
    check("rst_req_ready",  bus.req_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_store", bus.resp_store, 0);
    check("rst_resp_rob",   bus.resp_rob, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_resp_fault", bus.resp_fault, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
    check("post_rst_ready", bus.req_ready, 1);

    // Give every RAM word a known value.
    bus.resp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) send(1'b1, 16'(i), 16'(i * 257) ^ 16'h5A5A, 5'(i));
    drain();

    // Load latency: accepted at edge t, visible after t+2, ready back after t+2.
    send(1'b0, 16'h0010, 16'h0000, 5'd3);
    check("lat_t0_ready", bus.req_ready, 0);
    check("lat_t0_valid", bus.resp_valid, 0);
    step();
    check("lat_t1_ready", bus.req_ready, 0);
    check("lat_t1_valid", bus.resp_valid, 0);
    step();
    check("lat_t2_valid", bus.resp_valid, 1);
    check("lat_t2_rob",   bus.resp_rob, 3);
    check("lat_t2_store", bus.resp_store, 0);
    check("lat_t2_ready", bus.req_ready, 1);
    drain();

    // Table vectors with hand-computed expectations.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].st, vecs[i].addr, vecs[i].wd, vecs[i].rob);
      pop_check("vec", vecs[i].st, vecs[i].rob, vecs[i].exp_rdata, 1'b0);
    end
    drain();

    // Full queue backpressure.
    for (int i = 0; i < 4; i++) send(1'b0, 16'h0030 + 16'(i), 16'h0000, 5'(i + 1));
    step(); step();
    check("bp_full_ready", bus.req_ready, 0);
    check("bp_full_head",  bus.resp_rob, 1);
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check("bp_pop_head",  bus.resp_rob, 2);
    check("bp_pop_ready", bus.req_ready, 1);
    drain();

    // Enqueue and pop on the same edge with three entries queued.
    for (int i = 0; i < 3; i++) send(1'b0, 16'h0040 + 16'(i), 16'h0000, 5'(i + 5));
    send(1'b0, 16'h0043, 16'h0000, 5'd8);
    step();
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check("same_edge_ready", bus.req_ready, 1);
    check("same_edge_valid", bus.resp_valid, 1);
    check("same_edge_head",  bus.resp_rob, 6);
    drain();

    // Address fault / aliasing.
    saved = model_mem[5];
    send(1'b1, 16'h0105, 16'h5555, 5'd12);
    send(1'b0, 16'h0005, 16'h0000, 5'd13);
    pop_check("flt_store", 1'b1, 5'd12, 16'h0000, FAULT_EN);
    pop_check("flt_load",  1'b0, 5'd13, FAULT_EN ? saved : 16'h5555, 1'b0);
    drain();

    // Reset during WAIT of a store, with one completion already queued.
    send(1'b0, 16'h0006, 16'h0000, 5'd9);
    step(); step(); step();
    saved = model_mem[5];
    send(1'b1, 16'h0005, 16'h1234, 5'd10);
    rst = 1'b1;
    #1;
    check("mid_rst_req_ready",  bus.req_ready, 0);
    check("mid_rst_resp_valid", bus.resp_valid, 0);
    check("mid_rst_resp_store", bus.resp_store, 0);
    check("mid_rst_resp_rob",   bus.resp_rob, 0);
    check("mid_rst_resp_rdata", bus.resp_rdata, 0);
    check("mid_rst_resp_fault", bus.resp_fault, 0);
    exp_q.delete();
    model_mem[5] = saved;
    step();
    step();
    rst = 1'b0;
    step();
    send(1'b0, 16'h0005, 16'h0000, 5'd11);
    pop_check("rst_reload", 1'b0, 5'd11, saved, 1'b0);
    drain();

    // Randomized traffic with random consumer backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          ra = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15)) : 16'($urandom);
          send(1'($urandom_range(0, 1)), ra, 16'($urandom), 5'($urandom));
          for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          step();
          bus.resp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end
endmodule
